icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, one-word-per-frame instruction cache. A hit in
//            IDLE returns the cached word in the same cycle. A miss latches
//            the word-aligned address and moves to FETCH, which holds the
//            memory read until iwait drops, then fills the frame.
// Ports    : CLK, nRST (synchronous, active-high reset)
//            iflush                 - invalidate every frame
//            imemREN, imemaddr      - datapath fetch request / address
//            ihit, imemload         - hit flag / instruction word (0 on miss)
//            iREN, iaddr            - memory read request / word address
//            iwait, iload           - memory busy / memory read data
//            hitcnt, misscnt        - statistics counters
// Config   : define ICACHE_STATS_EN to build the hit/miss counters;
//            without it hitcnt and misscnt are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iflush,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t             r_state;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [29:0]        r_addr;     // latched word address of the fetch
    logic               r_drop;     // a flush was seen during this fetch

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic               w_unused_ok;

    assign w_idx      = imemaddr[IDX_W+1:2];
    assign w_tag      = imemaddr[31:IDX_W+2];
    assign w_fill_idx = r_addr[IDX_W-1:0];
    assign w_fill_tag = r_addr[29:IDX_W];

    // Byte offset within the word has no effect on the lookup.
    assign w_unused_ok = ^imemaddr[1:0];

    // Flush wins over a hit in the same cycle.
    assign w_hit  = (r_state == ST_IDLE) && imemREN && !iflush &&
                    r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == ST_IDLE) && imemREN && !w_hit;

    // Completion writes unless a flush arrived at any point during the fetch
    // (including the completion cycle itself) or reset is being applied.
    assign w_fill = (r_state == ST_FETCH) && !iwait && !r_drop && !iflush && !nRST;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;
    assign iREN     = (r_state == ST_FETCH);
    assign iaddr    = (r_state == ST_FETCH) ? {r_addr, 2'b00} : 32'h0;

    // Control state, latched address and valid bits.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_drop  <= 1'b0;
            r_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_state <= ST_FETCH;
                        r_addr  <= imemaddr[31:2];
                        r_drop  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!iwait) begin
                        r_state <= ST_IDLE;
                    end else if (iflush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (iflush) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits qualify it.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hitcnt;
    logic [31:0] r_misscnt;

    // w_hit only occurs in IDLE; w_miss is exactly the IDLE-to-FETCH step.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_hitcnt  <= '0;
            r_misscnt <= '0;
        end else begin
            if (w_hit) begin
                r_hitcnt <= r_hitcnt + 32'd1;
            end
            if (w_miss) begin
                r_misscnt <= r_misscnt + 32'd1;
            end
        end
    end

    assign hitcnt  = r_hitcnt;
    assign misscnt = r_misscnt;
`else
    assign hitcnt  = 32'h0;
    assign misscnt = 32'h0;
`endif

endmodule

`default_nettype wire
